// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register address width, forward-select encodings
// and the shadow-pipe entry that tracks one in-flight producer.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_RF     = 0;
  localparam int READY_ALU  = 1;
  localparam int READY_LOAD = 2;
  localparam int STAGE_W    = 8;

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic [STAGE_W-1:0]    rs_stage;
  } shadow_entry_t;

  // Out-of-range ready stages are treated as the deepest latch, the safest choice.
  function automatic logic [STAGE_W-1:0] norm_ready(input int unsigned ready,
                                                    input int unsigned depth);
    if (ready < READY_ALU || ready > depth) begin
      return STAGE_W'(depth);
    end
    return STAGE_W'(ready);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source register against the shadow pipe; the youngest
// producer wins and either forwards from its latch or raises a hazard.
module fwd_src_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  shadow_entry_t         i_pipe [1:DEPTH],
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_used,
  output logic [SW-1:0]         o_sel,
  output logic                  o_hazard
);

  // Scan oldest to youngest so the youngest matching producer overwrites the result.
  always_comb begin
    o_sel    = SW'(FWD_RF);
    o_hazard = 1'b0;
    for (int j = DEPTH; j >= 1; j--) begin
      if (i_used && i_pipe[j].v && (i_pipe[j].rd == i_rs)) begin
        if (j >= int'(i_pipe[j].rs_stage)) begin
          o_sel    = SW'(j);
          o_hazard = 1'b0;
        end else begin
          o_sel    = SW'(FWD_RF);
          o_hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks producers in a shadow pipe beside
// ID/EX, stalls ID on unready operands and registers forward selects into EX.
module fwd_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SW      = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]              id_rs_used,
  input  logic                            id_reg_write,
  input  logic [REG_ADDR_W-1:0]           id_rd,
  input  logic [SW-1:0]                   id_ready_stage,
  input  logic                            flush,
  input  logic                            freeze,
  output logic                            stall,
  output logic [NUM_SRC*SW-1:0]           ex_fwd_sel,
  output logic [31:0]                     stall_count
);

  shadow_entry_t              r_pipe [1:DEPTH];
  logic [NUM_SRC*SW-1:0]      r_exFwdSel;
  logic [31:0]                r_stallCount;

  logic [NUM_SRC*SW-1:0]      w_sel;
  logic [NUM_SRC-1:0]         w_hazard;
  logic                       w_stall;
  logic                       w_insert;
  logic                       w_issueFwd;
  shadow_entry_t              w_newEntry;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_match
    fwd_src_match #(
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_match (
      .i_pipe   (r_pipe),
      .i_rs     (id_rs[REG_ADDR_W*p +: REG_ADDR_W]),
      .i_used   (id_rs_used[p]),
      .o_sel    (w_sel[SW*p +: SW]),
      .o_hazard (w_hazard[p])
    );
  end

  // x0 is never entered as valid, so reads of x0 can never match or stall.
  assign w_stall    = id_valid & ~flush & (|w_hazard);
  assign w_insert   = id_valid & id_reg_write & (id_rd != '0) & ~flush & ~w_stall;
  assign w_issueFwd = id_valid & ~flush & ~w_stall;

  assign w_newEntry.v        = w_insert;
  assign w_newEntry.rd       = id_rd;
  assign w_newEntry.rs_stage = norm_ready(32'(id_ready_stage), 32'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
      r_exFwdSel   <= '0;
      r_stallCount <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      r_pipe[1]  <= w_newEntry;
      r_exFwdSel <= w_issueFwd ? w_sel : {NUM_SRC{SW'(FWD_RF)}};
      if (w_stall && (r_stallCount != '1)) begin
        r_stallCount <= r_stallCount + 32'd1;
      end
    end
  end

  assign stall       = w_stall;
  assign ex_fwd_sel  = r_exFwdSel;
  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench: a 2x2 and a 3x3 scoreboard driven by directed and random
// instruction streams, compared against a producer-age reference model.
module tb_fwd_scoreboard;
  import pipe_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [14:0] rs;
    logic [2:0]  used;
    logic        regWrite;
    logic [4:0]  rd;
    logic [1:0]  ready;
    logic        flush;
    logic        freeze;
  } stim_t;

  typedef struct {
    int dut;
    int rd;
    int ready;
    int age;
  } prod_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  stim_t       stA, stB;
  logic        stallA, stallB;
  logic [3:0]  exSelA;
  logic [5:0]  exSelB;
  logic [31:0] cntA, cntB;

  int          checks = 0;
  int          failures = 0;
  prod_t       q[$];
  logic [5:0]  expSel [2];
  logic [31:0] expCnt [2];
  logic        lastStallA, lastStallB;
  stim_t       NOP;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NUM_SRC(2), .DEPTH(2)) dutA (
    .clk(clk), .rst(rst), .id_valid(stA.valid), .id_rs(stA.rs[9:0]),
    .id_rs_used(stA.used[1:0]), .id_reg_write(stA.regWrite), .id_rd(stA.rd),
    .id_ready_stage(stA.ready), .flush(stA.flush), .freeze(stA.freeze),
    .stall(stallA), .ex_fwd_sel(exSelA), .stall_count(cntA)
  );

  fwd_scoreboard #(.NUM_SRC(3), .DEPTH(3)) dutB (
    .clk(clk), .rst(rst), .id_valid(stB.valid), .id_rs(stB.rs),
    .id_rs_used(stB.used), .id_reg_write(stB.regWrite), .id_rd(stB.rd),
    .id_ready_stage(stB.ready), .flush(stB.flush), .freeze(stB.freeze),
    .stall(stallB), .ex_fwd_sel(exSelB), .stall_count(cntB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t mk(input int v, input int rs0, input int rs1, input int rs2,
                               input int used, input int rw, input int rd, input int ready,
                               input int fl, input int fr);
    stim_t s;
    s.valid    = 1'(v);
    s.rs       = {5'(rs2), 5'(rs1), 5'(rs0)};
    s.used     = 3'(used);
    s.regWrite = 1'(rw);
    s.rd       = 5'(rd);
    s.ready    = 2'(ready);
    s.flush    = 1'(fl);
    s.freeze   = 1'(fr);
    return s;
  endfunction

  // Youngest in-flight writer of each source decides: forward from its age if ready, else stall.
  function automatic void modelEval(input int d, input int nsrc, input stim_t s,
                                    output logic stallExp, output logic [5:0] selExp);
    logic haz = 1'b0;
    selExp = '0;
    for (int p = 0; p < nsrc; p++) begin
      int best = -1;
      int rsv  = int'(s.rs[5*p +: 5]);
      if (s.used[p]) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].dut == d && q[i].rd == rsv && (best < 0 || q[i].age < q[best].age)) best = i;
        end
        if (best >= 0) begin
          if (q[best].age >= q[best].ready) selExp[2*p +: 2] = 2'(q[best].age);
          else haz = 1'b1;
        end
      end
    end
    stallExp = s.valid & ~s.flush & haz;
  endfunction

  function automatic void modelEdge(input int d, input int depth, input stim_t s,
                                    input logic stallExp, input logic [5:0] selExp);
    prod_t n;
    int    rdy;
    if (s.freeze) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].dut == d) begin
        q[i].age++;
        if (q[i].age > depth) q.delete(i);
      end
    end
    if (s.valid && s.regWrite && s.rd != 0 && !s.flush && !stallExp) begin
      rdy = int'(s.ready);
      if (rdy == 0 || rdy > depth) rdy = depth;
      n.dut = d; n.rd = int'(s.rd); n.ready = rdy; n.age = 1;
      q.push_back(n);
    end
    expSel[d] = (stallExp || s.flush || !s.valid) ? 6'd0 : selExp;
    if (stallExp && expCnt[d] != 32'hFFFF_FFFF) expCnt[d] = expCnt[d] + 1;
  endfunction

  function automatic void modelReset();
    q.delete();
    expSel[0] = '0; expSel[1] = '0;
    expCnt[0] = '0; expCnt[1] = '0;
  endfunction

  // One pipeline cycle for both units: stall checked mid-cycle, registered outputs after the edge.
  task automatic applyStimulus(input stim_t a, input stim_t b);
    logic       sA, sB;
    logic [5:0] selA, selB;
    @(negedge clk);
    stA = a;
    stB = b;
    #1;
    modelEval(0, 2, a, sA, selA);
    modelEval(1, 3, b, sB, selB);
    lastStallA = stallA;
    lastStallB = stallB;
    checkOutput("stallA", 32'(stallA), 32'(sA));
    checkOutput("stallB", 32'(stallB), 32'(sB));
    @(posedge clk);
    #1;
    modelEdge(0, 2, a, sA, selA);
    modelEdge(1, 3, b, sB, selB);
    checkOutput("selA", 32'(exSelA), 32'(expSel[0][3:0]));
    checkOutput("selB", 32'(exSelB), 32'(expSel[1]));
    checkOutput("countA", cntA, expCnt[0]);
    checkOutput("countB", cntB, expCnt[1]);
  endtask

  task automatic drain();
    repeat (3) applyStimulus(NOP, NOP);
  endtask

  initial begin
    stim_t cons;
    int    nStall;
    NOP = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stA = NOP;
    stB = NOP;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetStallA", 32'(stallA), 32'd0);
    checkOutput("resetSelA", 32'(exSelA), 32'd0);
    checkOutput("resetCountA", cntA, 32'd0);
    checkOutput("resetSelB", 32'(exSelB), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(mk(1, 1, 2, 0, 3, 1, 5, READY_ALU, 0, 0), NOP);
    applyStimulus(mk(1, 5, 5, 0, 3, 1, 6, READY_ALU, 0, 0), NOP);
    checkOutput("aluNoStall", 32'(lastStallA), 32'd0);
    checkOutput("aluBackToBack", 32'(exSelA), 32'h5);
    drain();

    applyStimulus(mk(1, 1, 2, 0, 3, 1, 5, READY_ALU, 0, 0), NOP);
    applyStimulus(mk(1, 1, 2, 0, 3, 1, 10, READY_ALU, 0, 0), NOP);
    applyStimulus(mk(1, 5, 1, 0, 3, 1, 11, READY_ALU, 0, 0), NOP);
    checkOutput("aluOneApart", 32'(exSelA), 32'h2);
    drain();

    cons = mk(1, 7, 1, 0, 3, 1, 8, READY_ALU, 0, 0);
    applyStimulus(mk(1, 1, 0, 0, 1, 1, 7, READY_LOAD, 0, 0), NOP);
    applyStimulus(cons, NOP);
    checkOutput("loadUseStall", 32'(lastStallA), 32'd1);
    checkOutput("loadUseBubble", 32'(exSelA), 32'd0);
    applyStimulus(cons, NOP);
    checkOutput("loadUseRelease", 32'(lastStallA), 32'd0);
    checkOutput("loadUseSel", 32'(exSelA), 32'h2);
    checkOutput("loadUseCount", cntA, 32'd1);
    drain();

    applyStimulus(mk(1, 1, 2, 0, 3, 1, 3, READY_ALU, 0, 0), NOP);
    applyStimulus(mk(1, 1, 2, 0, 3, 1, 3, READY_ALU, 0, 0), NOP);
    applyStimulus(mk(1, 3, 0, 0, 3, 1, 4, READY_ALU, 0, 0), NOP);
    checkOutput("youngestWins", 32'(exSelA), 32'h1);
    drain();

    applyStimulus(mk(1, 1, 0, 0, 1, 1, 0, READY_LOAD, 0, 0), NOP);
    applyStimulus(mk(1, 0, 0, 0, 1, 1, 9, READY_ALU, 0, 0), NOP);
    checkOutput("x0NoStall", 32'(lastStallA), 32'd0);
    checkOutput("x0Sel", 32'(exSelA), 32'd0);
    drain();

    applyStimulus(mk(1, 1, 0, 0, 1, 1, 7, READY_LOAD, 0, 0), NOP);
    applyStimulus(mk(1, 7, 1, 0, 3, 1, 8, READY_ALU, 1, 0), NOP);
    checkOutput("flushNoStall", 32'(lastStallA), 32'd0);
    applyStimulus(mk(1, 7, 1, 0, 3, 1, 12, READY_ALU, 0, 0), NOP);
    checkOutput("flushThenSel", 32'(exSelA), 32'h2);
    drain();

    applyStimulus(mk(1, 1, 0, 0, 1, 1, 7, READY_LOAD, 0, 0), NOP);
    repeat (3) applyStimulus(mk(1, 7, 1, 0, 3, 1, 8, READY_ALU, 0, 1), NOP);
    checkOutput("freezeStall", 32'(lastStallA), 32'd1);
    checkOutput("freezeCount", cntA, 32'd1);
    applyStimulus(cons, NOP);
    checkOutput("freezeResumeStall", 32'(lastStallA), 32'd1);
    applyStimulus(cons, NOP);
    checkOutput("freezeResumeSel", 32'(exSelA), 32'h2);
    checkOutput("freezeResumeCount", cntA, 32'd2);
    drain();

    applyStimulus(mk(1, 1, 0, 0, 1, 1, 7, READY_LOAD, 0, 0), NOP);
    @(negedge clk);
    stA = cons;
    #1;
    checkOutput("preResetStall", 32'(stallA), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midResetStall", 32'(stallA), 32'd0);
    checkOutput("midResetSel", 32'(exSelA), 32'd0);
    checkOutput("midResetCount", cntA, 32'd0);
    modelReset();
    stA = NOP;
    @(negedge clk);
    rst = 1'b0;

    nStall = 0;
    applyStimulus(NOP, mk(1, 1, 0, 0, 1, 1, 13, 3, 0, 0));
    repeat (3) begin
      applyStimulus(NOP, mk(1, 13, 0, 0, 1, 1, 14, READY_ALU, 0, 0));
      nStall += int'(lastStallB);
    end
    checkOutput("depth3StallCycles", 32'(nStall), 32'd2);
    checkOutput("depth3Sel", 32'(exSelB), 32'h3);
    checkOutput("depth3Count", cntB, 32'd2);
    drain();

    for (int c = 0; c < 600; c++) begin
      stim_t r [2];
      for (int d = 0; d < 2; d++) begin
        r[d] = mk(($urandom_range(0, 99) < 85) ? 1 : 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 80) ? 1 : 0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
      applyStimulus(r[0], r[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
